dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port: accepts one load/store request at a time over a valid/ready request channel, waits a fixed programmable latency, then returns a valid/ready response. It replaces the zero-latency combinational RAM model behind the core so that simulation can exercise a multi-cycle memory system. Internal storage is a 64-bit-word array mapped at `BASE_ADDR`.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic [63:0] DMEM_BASE        = 64'h0000_0000_8000_0000;
    localparam int          DMEM_MAX_LATENCY = 15;
    localparam int          DMEM_CNT_W       = $clog2(DMEM_MAX_LATENCY + 1);

    typedef struct packed {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port 64-bit word array with byte-lane write enables; a read on the
// same edge as a write returns the pre-write word.
module dmem_array #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [63:0]           wdata,
    input  logic [7:0]            wmask,
    output logic [63:0]           rdata
);

    logic [63:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (en) begin
            rdata <= mem[addr];
            if (wen) begin
                for (int i = 0; i < 8; i++) begin
                    if (wmask[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed latency,
// response held until the requester takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int          LATENCY    = 2,
    parameter logic [63:0] BASE_ADDR  = DMEM_BASE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output dmem_state_e state_dbg
);

    // Both channels transfer on a clock edge where valid and ready are both 1;
    // the sender holds its payload stable until that edge.

    localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
        (LATENCY > 1) ? DMEM_CNT_W'(LATENCY - 2) : '0;

    dmem_state_e           state, state_d;
    logic [DMEM_CNT_W-1:0] cnt, cnt_d;
    dmem_req_t             req_q, cur_req;
    logic                  accept, commit;
    logic [60:0]           word_off;
    logic                  in_range;
    logic                  rd_sel;
    logic [63:0]           arr_rdata;

    // With LATENCY=1 the commit edge is the accept edge, so use the live request.
    always_comb begin
        if (state == IDLE) begin
            cur_req.addr  = req_addr;
            cur_req.wen   = req_wen;
            cur_req.wdata = req_wdata;
            cur_req.wmask = req_wmask;
        end else begin
            cur_req = req_q;
        end
    end

    assign word_off = 61'((cur_req.addr - BASE_ADDR) >> 3);
    assign in_range = (cur_req.addr >= BASE_ADDR) && (word_off[60:ADDR_WIDTH] == '0);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            resp_err <= 1'b0;
            rd_sel   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (commit) begin
                resp_err <= ~in_range;
                rd_sel   <= in_range & ~cur_req.wen;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            req_q <= cur_req;
        end
    end

    // Reset suppresses the commit so a store caught in WAIT never lands.
    dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
        .clock (clock),
        .en    (commit & in_range & ~reset),
        .wen   (commit & in_range & ~reset & cur_req.wen),
        .addr  (word_off[ADDR_WIDTH-1:0]),
        .wdata (cur_req.wdata),
        .wmask (cur_req.wmask),
        .rdata (arr_rdata)
    );

    assign resp_rdata = rd_sel ? arr_rdata : '0;
    assign req_ready  = (state == IDLE) & ~reset;
    assign resp_valid = (state == RESP) & ~reset;
    assign state_dbg  = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 instance for function/corner cases,
// LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int L2 = 2;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
    logic [63:0] req_addr, req_wdata, resp_rdata;
    logic [7:0]  req_wmask;
    dmem_state_e state_dbg;

    logic        l1_req_valid, l1_req_ready, l1_req_wen, l1_resp_valid, l1_resp_ready, l1_resp_err;
    logic [63:0] l1_req_addr, l1_req_wdata, l1_resp_rdata;
    logic [7:0]  l1_req_wmask;
    dmem_state_e l1_state_dbg;

    logic [64:0] exp_q[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    dmem_responder #(.ADDR_WIDTH(12), .LATENCY(L2), .BASE_ADDR(64'h8000_0000)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .state_dbg(state_dbg)
    );

    dmem_responder #(.ADDR_WIDTH(12), .LATENCY(1), .BASE_ADDR(64'h8000_0000)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_addr(l1_req_addr),
        .req_wen(l1_req_wen), .req_wdata(l1_req_wdata), .req_wmask(l1_req_wmask),
        .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
        .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err), .state_dbg(l1_state_dbg)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_resp(input string name, input logic [63:0] rd, input logic er);
        logic [64:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s actual=response expected=empty_queue", name);
        end else begin
            e = exp_q.pop_front();
            check({name, "_rdata"}, rd, e[63:0]);
            check({name, "_err"}, 64'(er), 64'(e[64]));
        end
    endtask

    // ---------------- driver (LATENCY=2 instance) ----------------
    // Entered and left on a negedge with the DUT idle and resp_ready=1.
    task automatic txn(input vec_t v, input string name);
        int k;
        check({name, "_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_wen   = v.wen;
        req_wdata = v.wdata;
        req_wmask = v.wmask;
        exp_q.push_back({v.exp_err, v.exp_rdata});
        @(negedge clock);
        req_valid = 1'b0;
        k = 1;
        while (!resp_valid && k < 50) begin
            @(negedge clock);
            k++;
        end
        check({name, "_lat"}, 64'(k), 64'(L2));
        check_resp(name, resp_rdata, resp_err);
        @(negedge clock);
    endtask

    initial begin
        int   k, last;
        logic [64:0] e;
        logic [7:0]  b;

        reset = 1'b1;
        req_valid = 0; req_addr = 0; req_wen = 0; req_wdata = 0; req_wmask = 0; resp_ready = 1;
        l1_req_valid = 0; l1_req_addr = 0; l1_req_wen = 0; l1_req_wdata = 0; l1_req_wmask = 0;
        l1_resp_ready = 1;

        // stimulus table: {addr, wen, wdata, wmask, exp_err, exp_rdata}
        vecs.push_back('{64'h8000_0000, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b0, 64'h0});
        vecs.push_back('{64'h8000_0010, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 64'h0});
        vecs.push_back('{64'h8000_0010, 1'b0, 64'h0, 8'h00, 1'b0, 64'h1122_3344_5566_7788});
        vecs.push_back('{64'h8000_0010, 1'b1, 64'hAAAA_0000_0000_00BB, 8'b1100_0001, 1'b0, 64'h0});
        vecs.push_back('{64'h8000_0010, 1'b0, 64'h0, 8'h00, 1'b0, 64'hAAAA_3344_5566_77BB});
        vecs.push_back('{64'h7FFF_FFF8, 1'b0, 64'h0, 8'h00, 1'b1, 64'h0});
        vecs.push_back('{64'h8000_8000, 1'b0, 64'h0, 8'h00, 1'b1, 64'h0});
        vecs.push_back('{64'h8000_8000, 1'b1, 64'h5555_5555_5555_5555, 8'hFF, 1'b1, 64'h0});
        vecs.push_back('{64'h8000_0000, 1'b0, 64'h0, 8'h00, 1'b0, 64'hDEAD_BEEF_0BAD_F00D});
        vecs.push_back('{64'h8000_0018, 1'b1, 64'h0000_0000_CAFE_F00D, 8'hFF, 1'b0, 64'h0});
        vecs.push_back('{64'h8000_0018, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0, 64'h0});
        vecs.push_back('{64'h8000_001C, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0000_0000_CAFE_F00D});
        vecs.push_back('{64'h8000_7FF8, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 64'h0});
        vecs.push_back('{64'h8000_7FFF, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0123_4567_89AB_CDEF});
        vecs.push_back('{64'h8000_0020, 1'b1, 64'h0, 8'hFF, 1'b0, 64'h0});
        vecs.push_back('{64'h8000_0020, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0});

        // reset values
        repeat (3) @(negedge clock);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_rdata", resp_rdata, 64'h0);
        check("rst_err", 64'(resp_err), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        check("l1_rst_resp_valid", 64'(l1_resp_valid), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 64'(req_ready), 64'd1);
        check("l1_post_rst_ready", 64'(l1_req_ready), 64'd1);

        // table-driven transactions
        for (int i = 0; i < vecs.size(); i++) begin
            txn(vecs[i], $sformatf("v%0d", i));
        end

        // back-pressure: load held in RESP while a store is offered
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 64'h8000_0010; req_wen = 1'b0; req_wmask = 8'h00;
        exp_q.push_back({1'b0, 64'hAAAA_3344_5566_77BB});
        @(negedge clock);
        req_valid = 1'b0;
        k = 1;
        while (!resp_valid && k < 50) begin
            @(negedge clock);
            k++;
        end
        check("bp_lat", 64'(k), 64'(L2));
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_rdata%0d", i), resp_rdata, e[63:0]);
            check($sformatf("bp_err%0d", i), 64'(resp_err), 64'(e[64]));
            check($sformatf("bp_valid%0d", i), 64'(resp_valid), 64'd1);
            check($sformatf("bp_req_ready%0d", i), 64'(req_ready), 64'd0);
            req_valid = 1'b1; req_wen = 1'b1; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_wmask = 8'hFF;
            @(negedge clock);
        end
        check("bp_rdata_last", resp_rdata, e[63:0]);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        check("bp_idle_state", 64'(state_dbg), 64'(IDLE));
        check("bp_idle_ready", 64'(req_ready), 64'd1);
        txn('{64'h8000_0010, 1'b0, 64'h0, 8'h00, 1'b0, 64'hAAAA_3344_5566_77BB}, "bp_reload");

        // reset while a store waits: the store must not land
        req_valid = 1'b1; req_addr = 64'h8000_0020; req_wen = 1'b1;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_wmask = 8'hFF;
        @(negedge clock);
        req_valid = 1'b0;
        check("mr_in_wait", 64'(state_dbg), 64'(WAIT));
        reset = 1'b1;
        @(negedge clock);
        check("mr_req_ready", 64'(req_ready), 64'd0);
        check("mr_resp_valid", 64'(resp_valid), 64'd0);
        check("mr_rdata", resp_rdata, 64'h0);
        check("mr_err", 64'(resp_err), 64'd0);
        check("mr_state", 64'(state_dbg), 64'(IDLE));
        reset = 1'b0;
        @(negedge clock);
        txn('{64'h8000_0020, 1'b0, 64'h0, 8'h00, 1'b0, 64'h0}, "mr_reload");

        // LATENCY=1 throughput: request held valid, new payload after each handshake
        last = 0;
        l1_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("l1_ready%0d", i), 64'(l1_req_ready), 64'd1);
            if (i < 4) begin
                b = 8'(i + 1);
                l1_req_addr = 64'h8000_0000 + 64'(8 * i);
                l1_req_wen = 1'b1; l1_req_wdata = {8{b}}; l1_req_wmask = 8'hFF;
                exp_q.push_back({1'b0, 64'h0});
            end else begin
                b = 8'(i - 3);
                l1_req_addr = 64'h8000_0000 + 64'(8 * (i - 4));
                l1_req_wen = 1'b0; l1_req_wdata = 64'h0; l1_req_wmask = 8'h00;
                exp_q.push_back({1'b0, {8{b}}});
            end
            @(negedge clock);
            check($sformatf("l1_valid%0d", i), 64'(l1_resp_valid), 64'd1);
            check_resp($sformatf("l1_t%0d", i), l1_resp_rdata, l1_resp_err);
            if (i > 0) check($sformatf("l1_spacing%0d", i), 64'(cyc - last), 64'd2);
            last = cyc;
            @(negedge clock);
        end
        l1_req_valid = 1'b0;
        @(negedge clock);
        check("l1_idle", 64'(l1_state_dbg), 64'(IDLE));
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
